// File: rtl/mips_enc_pkg.sv
// Shared encoding constants and op enumeration for the instruction stream encoder
// and the EX-stage control decoder.
package mips_enc_pkg;

  typedef enum logic [4:0] {
    ENC_ADD, ENC_ADDU, ENC_SUB, ENC_SUBU, ENC_AND, ENC_OR, ENC_XOR, ENC_NOR,
    ENC_SLT, ENC_SLTU, ENC_MULT, ENC_MULTU, ENC_MFHI, ENC_MFLO,
    ENC_SLL, ENC_SRL, ENC_SRA, ENC_GPIO_WR, ENC_GPIO_RD,
    ENC_ADDI, ENC_ADDIU, ENC_SLTI, ENC_ANDI, ENC_ORI, ENC_XORI, ENC_LUI
  } enc_op_t;

  typedef enum logic [1:0] {
    ST_IDLE, ST_RUN, ST_PAD, ST_DONE
  } enc_state_t;

  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_ADDIU = 6'h09;
  localparam logic [5:0] OPC_SLTI  = 6'h0A;
  localparam logic [5:0] OPC_ANDI  = 6'h0C;
  localparam logic [5:0] OPC_ORI   = 6'h0D;
  localparam logic [5:0] OPC_XORI  = 6'h0E;
  localparam logic [5:0] OPC_LUI   = 6'h0F;

  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

  // True for every defined op whose decoded form writes a general-purpose register
  function automatic logic enc_is_gpr_wr(input logic [4:0] op);
    return (op <= ENC_LUI) && (op != ENC_MULT) && (op != ENC_MULTU);
  endfunction

endpackage

// File: rtl/instr_word_pack.sv
// Combinational packer: abstract op plus register/immediate fields -> 32-bit MIPS word.
module instr_word_pack
  import mips_enc_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        illegal,
  output logic        gpr_wr
);

  logic [5:0] funct;
  logic [5:0] opc;
  logic [4:0] sh;
  logic [4:0] rs_f;
  logic       itype;

  always_comb begin
    funct   = FUNCT_SLL;
    opc     = OPC_RTYPE;
    sh      = shamt;
    rs_f    = rs;
    itype   = 1'b0;
    illegal = 1'b0;
    case (op)
      ENC_ADD:   funct = FUNCT_ADD;
      ENC_ADDU:  funct = FUNCT_ADDU;
      ENC_SUB:   funct = FUNCT_SUB;
      ENC_SUBU:  funct = FUNCT_SUBU;
      ENC_AND:   funct = FUNCT_AND;
      ENC_OR:    funct = FUNCT_OR;
      ENC_XOR:   funct = FUNCT_XOR;
      ENC_NOR:   funct = FUNCT_NOR;
      ENC_SLT:   funct = FUNCT_SLT;
      ENC_SLTU:  funct = FUNCT_SLTU;
      ENC_MULT:  funct = FUNCT_MULT;
      ENC_MULTU: funct = FUNCT_MULTU;
      ENC_MFHI:  funct = FUNCT_MFHI;
      ENC_MFLO:  funct = FUNCT_MFLO;
      ENC_SLL:   funct = FUNCT_SLL;
      // shamt=0 shifts are reserved for the GPIO forms, so a real shift must move
      ENC_SRL: begin
        funct   = FUNCT_SRL;
        illegal = (shamt == 5'd0);
      end
      ENC_SRA: begin
        funct   = FUNCT_SRA;
        illegal = (shamt == 5'd0);
      end
      ENC_GPIO_WR: begin
        funct = FUNCT_SRL;
        sh    = 5'd0;
      end
      ENC_GPIO_RD: begin
        funct = FUNCT_SRA;
        sh    = 5'd0;
      end
      ENC_ADDI:  begin itype = 1'b1; opc = OPC_ADDI;  end
      ENC_ADDIU: begin itype = 1'b1; opc = OPC_ADDIU; end
      ENC_SLTI:  begin itype = 1'b1; opc = OPC_SLTI;  end
      ENC_ANDI:  begin itype = 1'b1; opc = OPC_ANDI;  end
      ENC_ORI:   begin itype = 1'b1; opc = OPC_ORI;   end
      ENC_XORI:  begin itype = 1'b1; opc = OPC_XORI;  end
      ENC_LUI: begin
        itype = 1'b1;
        opc   = OPC_LUI;
        rs_f  = 5'd0;
      end
      default:   illegal = 1'b1;
    endcase

    if (illegal) begin
      word = 32'h0;
    end else if (itype) begin
      word = {opc, rs_f, rt, imm};
    end else begin
      word = {OPC_RTYPE, rs_f, rt, rd, sh, funct};
    end
  end

  assign gpr_wr = !illegal && enc_is_gpr_wr(op);

endmodule

// File: rtl/instr_stream_encoder.sv
// Boot/self-test program loader: packs commands into MIPS words and writes imem sequentially.
// Optional hazard NOP padding after GPR-writing ops is enabled by defining ENC_HAZARD_PAD_EN.
module instr_stream_encoder
  import mips_enc_pkg::*;
#(
  parameter int ADDR_W  = 8,
  parameter int NOP_PAD = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [4:0]        cmd_op,
  input  logic [4:0]        cmd_rd,
  input  logic [4:0]        cmd_rs,
  input  logic [4:0]        cmd_rt,
  input  logic [4:0]        cmd_shamt,
  input  logic [15:0]       cmd_imm,
  input  logic              cmd_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   wr_count,
  output logic              err_illegal,
  output logic              err_overflow
);

`ifdef ENC_HAZARD_PAD_EN
  localparam bit PadEn = 1'b1;
`else
  localparam bit PadEn = 1'b0;
`endif
  localparam int PadLen = PadEn ? NOP_PAD : 0;
  localparam int PcW    = (PadLen < 2) ? 1 : $clog2(PadLen + 1);

  enc_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   count_q;
  logic [PcW-1:0]    pad_cnt_q;
  logic              last_pend_q;
  logic              err_illegal_q;
  logic              err_overflow_q;

  logic              vld_p1;
  logic [31:0]       word_p1;
  logic [ADDR_W-1:0] waddr_p1;

  logic [31:0]       pk_word;
  logic              pk_illegal;
  logic              pk_gpr;

  logic accept, cmd_wr, cmd_pad, at_end;
  logic pad_wr, pad_final, ovf_cmd, ovf_pad, any_wr;

  instr_word_pack u_pack (
    .op      (cmd_op),
    .rs      (cmd_rs),
    .rt      (cmd_rt),
    .rd      (cmd_rd),
    .shamt   (cmd_shamt),
    .imm     (cmd_imm),
    .word    (pk_word),
    .illegal (pk_illegal),
    .gpr_wr  (pk_gpr)
  );

  assign accept    = (state_q == ST_RUN) && cmd_valid;
  assign cmd_wr    = accept && !pk_illegal;
  assign cmd_pad   = cmd_wr && pk_gpr && (PadLen != 0);
  assign at_end    = &addr_q;
  assign pad_wr    = (state_q == ST_PAD);
  assign pad_final = (pad_cnt_q == PcW'(1));
  // A write to the last word is only allowed if nothing else of the program follows it
  assign ovf_cmd   = cmd_wr && at_end && (!cmd_last || cmd_pad);
  assign ovf_pad   = pad_wr && at_end && !(pad_final && last_pend_q);
  assign any_wr    = cmd_wr || pad_wr;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN: begin
        if (accept) begin
          if (ovf_cmd)       state_d = ST_DONE;
          else if (cmd_pad)  state_d = ST_PAD;
          else if (cmd_last) state_d = ST_DONE;
        end
      end
      ST_PAD: begin
        if (ovf_pad || (pad_final && last_pend_q)) state_d = ST_DONE;
        else if (pad_final)                        state_d = ST_RUN;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state_q == ST_RUN);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q         <= '0;
      count_q        <= '0;
      pad_cnt_q      <= '0;
      last_pend_q    <= 1'b0;
      err_illegal_q  <= 1'b0;
      err_overflow_q <= 1'b0;
    end else begin
      if ((state_q == ST_IDLE) && start) begin
        addr_q         <= base_addr;
        count_q        <= '0;
        err_illegal_q  <= 1'b0;
        err_overflow_q <= 1'b0;
      end else if (any_wr) begin
        if (!at_end) addr_q <= addr_q + 1'b1;
        count_q <= count_q + 1'b1;
      end
      if (accept && pk_illegal) err_illegal_q <= 1'b1;
      if (ovf_cmd || ovf_pad)   err_overflow_q <= 1'b1;
      if (cmd_pad) begin
        pad_cnt_q   <= PcW'(PadLen);
        last_pend_q <= cmd_last;
      end else if (pad_wr) begin
        pad_cnt_q <= pad_cnt_q - 1'b1;
      end
    end
  end

  // Stage 1: registered imem write port
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      word_p1  <= '0;
      waddr_p1 <= '0;
    end else begin
      vld_p1 <= any_wr;
      if (any_wr) begin
        word_p1  <= pad_wr ? 32'h0 : pk_word;
        waddr_p1 <= addr_q;
      end
    end
  end

  assign imem_we      = vld_p1;
  assign imem_addr    = waddr_p1;
  assign imem_wdata   = word_p1;
  assign wr_count     = count_q;
  assign err_illegal  = err_illegal_q;
  assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: vector table plus hand-written corner sequences,
// imem writes checked against a queue of expected {addr, word}.
module tb_instr_stream_encoder;
  import mips_enc_pkg::*;

`ifdef ENC_HAZARD_PAD_EN
  localparam int PAD_N = 3;
`else
  localparam int PAD_N = 0;
`endif

  typedef struct packed {
    logic [4:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  sh;
    logic [15:0] imm;
    logic        last;
    logic        legal;
    logic        gpr;
    logic [31:0] word;
  } vec_t;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_a, start_b;
  logic [7:0]  base_a;
  logic [3:0]  base_b;
  logic        valid_a, valid_b;
  logic [4:0]  op, rd, rs, rt, sh;
  logic [15:0] imm;
  logic        last;

  logic        ready_a, we_a, busy_a, done_a, eill_a, eovf_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  cnt_a;
  logic        ready_b, we_b, busy_b, done_b, eill_b, eovf_b;
  logic [3:0]  addr_b;
  logic [31:0] wdata_b;
  logic [4:0]  cnt_b;

  int   checks = 0;
  int   errors = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  int   ea_a, ea_b, nexp_a, nexp_b;
  int   done_cnt_b = 0;
  vec_t vecs[14];

  always #5 clk = ~clk;

  instr_stream_encoder #(.ADDR_W(8), .NOP_PAD(3)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .base_addr(base_a),
    .cmd_valid(valid_a), .cmd_ready(ready_a), .cmd_op(op), .cmd_rd(rd), .cmd_rs(rs),
    .cmd_rt(rt), .cmd_shamt(sh), .cmd_imm(imm), .cmd_last(last),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a), .busy(busy_a),
    .done(done_a), .wr_count(cnt_a), .err_illegal(eill_a), .err_overflow(eovf_a)
  );

  instr_stream_encoder #(.ADDR_W(4), .NOP_PAD(3)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .base_addr(base_b),
    .cmd_valid(valid_b), .cmd_ready(ready_b), .cmd_op(op), .cmd_rd(rd), .cmd_rs(rs),
    .cmd_rt(rt), .cmd_shamt(sh), .cmd_imm(imm), .cmd_last(last),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b), .busy(busy_b),
    .done(done_b), .wr_count(cnt_b), .err_illegal(eill_b), .err_overflow(eovf_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [4:0] o, input logic [4:0] d, input logic [4:0] s,
                              input logic [4:0] t, input logic [4:0] h, input logic [15:0] i,
                              input logic l, input logic lg, input logic g, input logic [31:0] w);
    vec_t v;
    v.op = o; v.rd = d; v.rs = s; v.rt = t; v.sh = h; v.imm = i;
    v.last = l; v.legal = lg; v.gpr = g; v.word = w;
    return v;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (we_a) begin
      if (q_a.size() == 0) begin
        chk("unexpected_write_a", {24'h0, addr_a}, 32'hFFFF_FFFF);
      end else begin
        e = q_a.pop_front();
        chk("imem_addr_a", {24'h0, addr_a}, {24'h0, e.addr});
        chk("imem_wdata_a", wdata_a, e.data);
      end
    end
    if (we_b) begin
      if (q_b.size() == 0) begin
        chk("unexpected_write_b", {28'h0, addr_b}, 32'hFFFF_FFFF);
      end else begin
        e = q_b.pop_front();
        chk("imem_addr_b", {28'h0, addr_b}, {24'h0, e.addr});
        chk("imem_wdata_b", wdata_b, e.data);
      end
    end
    if (done_b) done_cnt_b++;
  end

  task automatic do_start(input bit sel, input logic [7:0] base);
    if (sel) begin start_b = 1'b1; base_b = base[3:0]; ea_b = int'(base); nexp_b = 0; end
    else     begin start_a = 1'b1; base_a = base;      ea_a = int'(base); nexp_a = 0; end
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic send(input bit sel, input vec_t v, input int bound, output bit acc);
    exp_t e;
    op = v.op; rd = v.rd; rs = v.rs; rt = v.rt; sh = v.sh; imm = v.imm; last = v.last;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    acc = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (sel ? ready_b : ready_a) begin
        acc = 1'b1;
        if (v.legal) begin
          e.addr = sel ? 8'(ea_b) : 8'(ea_a);
          e.data = v.word;
          if (sel) begin q_b.push_back(e); ea_b++; nexp_b++; end
          else     begin q_a.push_back(e); ea_a++; nexp_a++; end
          if (v.gpr && !sel) begin
            for (int p = 0; p < PAD_N; p++) begin
              e.addr = 8'(ea_a);
              e.data = 32'h0;
              q_a.push_back(e); ea_a++; nexp_a++;
            end
          end
        end
      end
      @(posedge clk); #1;
      if (acc) break;
    end
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic wait_done_a(input int bound, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      if (done_a) begin seen = 1'b1; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc, seen;
    int lows;
    vec_t v;

    vecs[0]  = mk(ENC_ADD,     5'd3,  5'd1,  5'd2,  5'd0,  16'hBEEF, 1'b0, 1'b1, 1'b1, 32'h00221820);
    vecs[1]  = mk(ENC_ADDI,    5'd9,  5'd0,  5'd5,  5'd3,  16'hFFFF, 1'b0, 1'b1, 1'b1, 32'h2005FFFF);
    vecs[2]  = mk(ENC_LUI,     5'd9,  5'd9,  5'd7,  5'd3,  16'h1234, 1'b0, 1'b1, 1'b1, 32'h3C071234);
    vecs[3]  = mk(ENC_GPIO_WR, 5'd0,  5'd4,  5'd0,  5'd7,  16'hBEEF, 1'b0, 1'b1, 1'b1, 32'h00800002);
    vecs[4]  = mk(ENC_SLL,     5'd2,  5'd0,  5'd1,  5'd4,  16'hBEEF, 1'b0, 1'b1, 1'b1, 32'h00011100);
    vecs[5]  = mk(ENC_SRL,     5'd1,  5'd0,  5'd1,  5'd0,  16'h0000, 1'b0, 1'b0, 1'b0, 32'h0);
    vecs[6]  = mk(ENC_SUB,     5'd1,  5'd2,  5'd3,  5'd0,  16'hBEEF, 1'b0, 1'b1, 1'b1, 32'h00430822);
    vecs[7]  = mk(ENC_MULT,    5'd0,  5'd4,  5'd5,  5'd0,  16'hBEEF, 1'b0, 1'b1, 1'b0, 32'h00850018);
    vecs[8]  = mk(ENC_SRA,     5'd6,  5'd0,  5'd7,  5'd31, 16'hBEEF, 1'b0, 1'b1, 1'b1, 32'h000737C3);
    vecs[9]  = mk(ENC_GPIO_RD, 5'd8,  5'd0,  5'd0,  5'd0,  16'hBEEF, 1'b0, 1'b1, 1'b1, 32'h00004003);
    vecs[10] = mk(ENC_ORI,     5'd9,  5'd3,  5'd2,  5'd3,  16'h00FF, 1'b0, 1'b1, 1'b1, 32'h346200FF);
    vecs[11] = mk(5'd31,       5'd1,  5'd1,  5'd1,  5'd1,  16'h0001, 1'b0, 1'b0, 1'b0, 32'h0);
    vecs[12] = mk(ENC_NOR,     5'd31, 5'd31, 5'd31, 5'd0,  16'hBEEF, 1'b0, 1'b1, 1'b1, 32'h03FFF827);
    vecs[13] = mk(ENC_SLTU,    5'd1,  5'd1,  5'd1,  5'd0,  16'hBEEF, 1'b1, 1'b1, 1'b1, 32'h0021082B);

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; base_a = '0; base_b = '0;
    valid_a = 1'b0; valid_b = 1'b0;
    op = '0; rd = '0; rs = '0; rt = '0; sh = '0; imm = '0; last = 1'b0;
    ea_a = 0; ea_b = 0; nexp_a = 0; nexp_b = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_we", {31'h0, we_a}, 32'h0);
    chk("reset_busy", {31'h0, busy_a}, 32'h0);
    chk("reset_done", {31'h0, done_a}, 32'h0);
    chk("reset_ready", {31'h0, ready_a}, 32'h0);
    chk("reset_count", {23'h0, cnt_a}, 32'h0);
    chk("reset_errs", {30'h0, eill_a, eovf_a}, 32'h0);
    chk("reset_wdata", wdata_a, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Table-driven program on the 8-bit instance
    do_start(1'b0, 8'h00);
    @(negedge clk);
    chk("run_busy_ready", {30'h0, busy_a, ready_a}, 32'h3);
    @(posedge clk); #1;
    for (int i = 0; i < 14; i++) begin
      v = vecs[i];
      send(1'b0, v, 20, acc);
      chk($sformatf("accept_vec%0d", i), {31'h0, acc}, 32'h1);
      if (i == 0) chk("count_after_first", {23'h0, cnt_a}, 32'h1);
    end
    wait_done_a(40, seen);
    chk("table_done_seen", {31'h0, seen}, 32'h1);
    chk("table_count", {23'h0, cnt_a}, 32'(nexp_a));
    chk("table_err_illegal", {31'h0, eill_a}, 32'h1);
    chk("table_err_overflow", {31'h0, eovf_a}, 32'h0);
    @(negedge clk);
    chk("done_one_cycle", {30'h0, done_a, busy_a}, 32'h0);
    chk("table_queue_empty", 32'(q_a.size()), 32'h0);

    // Overflow on the 4-bit instance: base 14, three non-last commands
    @(posedge clk); #1;
    do_start(1'b1, 8'd14);
    v = mk(ENC_MULT, 5'd0, 5'd4, 5'd5, 5'd0, 16'h0, 1'b0, 1'b1, 1'b0, 32'h00850018);
    send(1'b1, v, 20, acc);
    chk("ovf_accept1", {31'h0, acc}, 32'h1);
    send(1'b1, v, 20, acc);
    chk("ovf_accept2", {31'h0, acc}, 32'h1);
    send(1'b1, v, 6, acc);
    chk("ovf_third_refused", {31'h0, acc}, 32'h0);
    chk("ovf_err_overflow", {31'h0, eovf_b}, 32'h1);
    chk("ovf_count", {27'h0, cnt_b}, 32'h2);
    chk("ovf_done_pulses", 32'(done_cnt_b), 32'h1);
    chk("ovf_busy", {31'h0, busy_b}, 32'h0);
    chk("ovf_queue_empty", 32'(q_b.size()), 32'h0);

    // Reset asserted the cycle after an accept aborts the load
    do_start(1'b0, 8'h20);
    @(negedge clk);
    chk("start_clears_errs", {30'h0, eill_a, eovf_a}, 32'h0);
    @(posedge clk); #1;
    send(1'b0, v, 20, acc);
    chk("rst_accept", {31'h0, acc}, 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_we", {31'h0, we_a}, 32'h0);
    chk("rst_busy", {31'h0, busy_a}, 32'h0);
    chk("rst_count", {23'h0, cnt_a}, 32'h0);
    chk("rst_addr_wdata", {24'h0, addr_a} | wdata_a, 32'h0);
    chk("rst_queue_empty", 32'(q_a.size()), 32'h0);

`ifdef ENC_HAZARD_PAD_EN
    // Hazard padding: ADD then MULT(last) -> ADD,0,0,0,MULT
    @(posedge clk); #1;
    do_start(1'b0, 8'h00);
    send(1'b0, vecs[0], 20, acc);
    chk("pad_accept_add", {31'h0, acc}, 32'h1);
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (!ready_a) lows++;
    end
    chk("pad_ready_low_cycles", 32'(lows), 32'h3);
    @(posedge clk); #1;
    v = mk(ENC_MULT, 5'd0, 5'd4, 5'd5, 5'd0, 16'h0, 1'b1, 1'b1, 1'b0, 32'h00850018);
    send(1'b0, v, 20, acc);
    chk("pad_accept_mult", {31'h0, acc}, 32'h1);
    wait_done_a(20, seen);
    chk("pad_done_seen", {31'h0, seen}, 32'h1);
    chk("pad_count", {23'h0, cnt_a}, 32'h5);
    @(negedge clk);
    chk("pad_queue_empty", 32'(q_a.size()), 32'h0);
`else
    lows = 0;
`endif

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
